// File: rtl/ws2812b_encoder_if.sv
// Pixel stream and latch-request channel from the peripheral register block
// into the WS2812B encoder.
interface ws2812b_encoder_if;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        latch;

  modport master (
    output pix_valid,
    output pix_data,
    output latch,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  latch,
    output pix_ready
  );
endinterface

// File: rtl/ws2812b_encoder.sv
// WS2812B transmitter: one-deep pixel holding buffer feeding an MSB-first NRZ
// pulse-width serialiser, plus an on-request low latch gap that commits the frame.
module ws2812b_encoder #(
  parameter int T0H_CYC   = 26,
  parameter int T1H_CYC   = 51,
  parameter int BIT_CYC   = 80,
  parameter int RESET_CYC = 3200
) (
  input  logic             clk,
  input  logic             rst_n,
  ws2812b_encoder_if.slave pix_if,
  output logic             dout,
  output logic             busy,
  output logic             latch_done
);

  localparam int MAX_CYC = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] T0H_LEN    = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H_LEN    = CNT_W'(T1H_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] cyc_q,      cyc_d;
  logic [4:0]       bit_q,      bit_d;
  logic [23:0]      shift_q,    shift_d;
  logic [23:0]      buf_q,      buf_d;
  logic             buf_full_q, buf_full_d;
  logic             pend_q,     pend_d;
  logic             dout_q,     dout_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             ready_q,    ready_d;

  logic             accept_s;
  logic             load_s;
  logic [CNT_W-1:0] hi_len_s;

  // Next-state logic for the serialiser FSM, holding buffer and registered outputs.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    load_s     = 1'b0;
    accept_s   = pix_if.pix_valid && ready_q;
    hi_len_s   = T0H_LEN;
    dout_d     = 1'b0;
    busy_d     = 1'b0;
    ready_d    = 1'b1;

    // A latch request is only remembered outside the gap it would trigger.
    if (pix_if.latch && (state_q != ST_LATCH)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (buf_full_q) begin
          load_s  = 1'b1;
          state_d = ST_SEND;
          shift_d = buf_q;
          bit_d   = 5'd23;
          cyc_d   = CNT_ZERO;
        end else if (pend_q) begin
          state_d = ST_LATCH;
          cyc_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (cyc_q != BIT_LAST) begin
          cyc_d = cyc_q + CNT_ONE;
        end else if (bit_q != 5'd0) begin
          cyc_d   = CNT_ZERO;
          bit_d   = bit_q - 5'd1;
          shift_d = {shift_q[22:0], 1'b0};
        end else if (buf_full_q) begin
          // Gapless hand-over: the next pixel's first bit starts on the following cycle.
          load_s  = 1'b1;
          state_d = ST_SEND;
          shift_d = buf_q;
          bit_d   = 5'd23;
          cyc_d   = CNT_ZERO;
        end else if (pend_q) begin
          state_d = ST_LATCH;
          cyc_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
          cyc_d   = CNT_ZERO;
        end
      end

      ST_LATCH: begin
        if (cyc_q != RESET_LAST) begin
          cyc_d = cyc_q + CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          cyc_d   = CNT_ZERO;
          pend_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = CNT_ZERO;
        bit_d   = 5'd0;
      end
    endcase

    if (accept_s) begin
      buf_d      = pix_if.pix_data;
      buf_full_d = 1'b1;
    end else if (load_s) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end

    // Outputs are derived from next state so the registered line matches cyc_q/shift_q.
    if (shift_d[23]) begin
      hi_len_s = T1H_LEN;
    end else begin
      hi_len_s = T0H_LEN;
    end

    if (state_d == ST_SEND) begin
      dout_d = (cyc_d < hi_len_s);
    end else begin
      dout_d = 1'b0;
    end

    busy_d  = (state_d != ST_IDLE) || buf_full_d || pend_d;
    ready_d = !buf_full_d;
  end

  // State, datapath and output registers; reset drops any partially sent pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cyc_q      <= CNT_ZERO;
      bit_q      <= 5'd0;
      shift_q    <= 24'd0;
      buf_q      <= 24'd0;
      buf_full_q <= 1'b0;
      pend_q     <= 1'b0;
      dout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      pend_q     <= pend_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign pix_if.pix_ready = ready_q;
  assign dout             = dout_q;
  assign busy             = busy_q;
  assign latch_done       = done_q;

endmodule
